// File: rtl/high_priority_encoder_8_3_pkg.sv
// Shared sizes and types for the 8:3 priority encoder.
package high_priority_encoder_8_3_pkg;
  localparam int NUM_INPUTS = 8;
  localparam int ENC_WIDTH  = 3;

  typedef logic [ENC_WIDTH-1:0] enc_idx_t;
endpackage

// File: rtl/high_priority_encoder_8_3_if.sv
// Request vector in, winning index plus valid out.
interface high_priority_encoder_8_3_if;
  import high_priority_encoder_8_3_pkg::*;

  logic [NUM_INPUTS-1:0] req;
  enc_idx_t              idx;
  logic                  valid;

  modport master (output req, input  idx, input  valid);
  modport slave  (input  req, output idx, output valid);
endinterface

// File: rtl/high_priority_encoder_8_3_priority_encode_comb.sv
// Combinational encoder: index of the highest set request bit.
module priority_encode_comb
  import high_priority_encoder_8_3_pkg::*;
(
  high_priority_encoder_8_3_if.slave bus
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    bus.idx = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (bus.req[i]) bus.idx = ENC_WIDTH'(i);
  end

  assign bus.valid = |bus.req;

endmodule

// File: rtl/high_priority_encoder_8_3.sv
// 8-input priority encoder, optionally registered, async active-low reset.
module high_priority_encoder_8_3
  import high_priority_encoder_8_3_pkg::*;
#(
  parameter bit REGISTER_OUTPUT = 1'b1
) (
  input  logic     Clock_In,
  input  logic     Reset_In,
  input  logic     Data_0_In,
  input  logic     Data_1_In,
  input  logic     Data_2_In,
  input  logic     Data_3_In,
  input  logic     Data_4_In,
  input  logic     Data_5_In,
  input  logic     Data_6_In,
  input  logic     Data_7_In,
  output enc_idx_t Encoded_Value_Out,
  output logic     Valid_Out
);

  high_priority_encoder_8_3_if enc_bus ();

  assign enc_bus.req = {Data_7_In, Data_6_In, Data_5_In, Data_4_In,
                        Data_3_In, Data_2_In, Data_1_In, Data_0_In};

  priority_encode_comb u_enc (.bus(enc_bus.slave));

  generate
    if (REGISTER_OUTPUT) begin : g_reg
      always_ff @(posedge Clock_In or negedge Reset_In) begin
        if (!Reset_In) begin
          Encoded_Value_Out <= '0;
          Valid_Out         <= 1'b0;
        end else begin
          Encoded_Value_Out <= enc_bus.idx;
          Valid_Out         <= enc_bus.valid;
        end
      end
    end else begin : g_comb
      // Reset still gates the outputs even with no register stage.
      always_comb begin
        Encoded_Value_Out = Reset_In ? enc_bus.idx   : '0;
        Valid_Out         = Reset_In ? enc_bus.valid : 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_high_priority_encoder_8_3.sv
// Directed bench for the registered 8:3 priority encoder.
module tb_high_priority_encoder_8_3;
  import high_priority_encoder_8_3_pkg::*;

  logic     clk;
  logic     rst_n;
  enc_idx_t enc_out;
  logic     vld_out;
  int       checks;
  int       errors;

  high_priority_encoder_8_3_if bus ();

  assign bus.idx   = enc_out;
  assign bus.valid = vld_out;

  high_priority_encoder_8_3 #(.REGISTER_OUTPUT(1'b1)) dut (
    .Clock_In          (clk),
    .Reset_In          (rst_n),
    .Data_0_In         (bus.req[0]),
    .Data_1_In         (bus.req[1]),
    .Data_2_In         (bus.req[2]),
    .Data_3_In         (bus.req[3]),
    .Data_4_In         (bus.req[4]),
    .Data_5_In         (bus.req[5]),
    .Data_6_In         (bus.req[6]),
    .Data_7_In         (bus.req[7]),
    .Encoded_Value_Out (enc_out),
    .Valid_Out         (vld_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan downward from the top bit, stop at the first set one.
  function automatic logic [3:0] ref_enc(input logic [7:0] d);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) begin
        r = {1'b1, 3'(i)};
        break;
      end
    end
    return r;
  endfunction

  // Drive at the falling edge, let the next rising edge capture it.
  task automatic apply(input logic [7:0] d);
    @(negedge clk);
    bus.req = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    #2;
    checks++;
    if (bus.idx !== 3'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got %0d/%0b want 0/0", bus.idx, bus.valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.idx !== 3'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got %0d/%0b want 0/0", bus.idx, bus.valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.idx !== 3'd7 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_edge: got %0d/%0b want 7/1", bus.idx, bus.valid);
    end
  endtask

  task automatic test_all_zero();
    apply(8'h00);
    checks++;
    if (bus.idx !== 3'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL all_zero: got %0d/%0b want 0/0", bus.idx, bus.valid);
    end
  endtask

  task automatic test_one_hot();
    logic [7:0] d;
    for (int n = 0; n < 8; n++) begin
      d = 8'h01 << n;
      apply(d);
      checks++;
      if (bus.idx !== 3'(n) || bus.valid !== 1'b1) begin
        errors++;
        $display("FAIL one_hot_%0d: got %0d/%0b want %0d/1", n, bus.idx, bus.valid, n);
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] vec [4];
    logic [2:0] exp_idx [4];
    vec = '{8'b1010_0101, 8'b0001_1111, 8'b0000_0011, 8'b0100_0000};
    exp_idx = '{3'd7, 3'd4, 3'd1, 3'd6};
    for (int k = 0; k < 4; k++) begin
      apply(vec[k]);
      checks++;
      if (bus.idx !== exp_idx[k] || bus.valid !== 1'b1) begin
        errors++;
        $display("FAIL priority_%b: got %0d/%0b want %0d/1", vec[k], bus.idx, bus.valid, exp_idx[k]);
      end
    end
  endtask

  task automatic test_random_exhaustive();
    logic [7:0] d;
    logic [3:0] r;
    for (int k = 0; k < 20 + 256; k++) begin
      d = (k < 20) ? 8'($urandom_range(0, 255)) : 8'(k - 20);
      r = ref_enc(d);
      apply(d);
      checks++;
      if (bus.idx !== r[2:0] || bus.valid !== r[3]) begin
        errors++;
        $display("FAIL pattern_%b: got %0d/%0b want %0d/%0b", d, bus.idx, bus.valid, r[2:0], r[3]);
      end
    end
  endtask

  task automatic test_async_reset();
    apply(8'b1000_0000);
    checks++;
    if (bus.idx !== 3'd7 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got %0d/%0b want 7/1", bus.idx, bus.valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.idx !== 3'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL async_assert: got %0d/%0b want 0/0", bus.idx, bus.valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.idx !== 3'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL async_release: got %0d/%0b want 0/0", bus.idx, bus.valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.idx !== 3'd7 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL async_first_edge: got %0d/%0b want 7/1", bus.idx, bus.valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_all_zero();
    test_one_hot();
    test_priority();
    test_random_exhaustive();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/high_priority_encoder_8_3.md
Name: high_priority_encoder_8_3

Overview:
8-input to 3-bit priority encoder. The highest-numbered asserted input wins. The result is registered on one clock with an async active-low reset. A valid flag distinguishes "input 0 asserted" from "no input asserted". It is used wherever a group of request/flag lines must be reduced to the index of the most significant active line.

Parameters:
REGISTER_OUTPUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational and Clock_In unused (reset still forces outputs to 0 while asserted).

Ports:
Clock_In  input  1  single clock, rising-edge active
Reset_In  input  1  asynchronous, active-low reset
Data_0_In  input  1  request line 0 (lowest priority)
Data_1_In  input  1  request line 1
Data_2_In  input  1  request line 2
Data_3_In  input  1  request line 3
Data_4_In  input  1  request line 4
Data_5_In  input  1  request line 5
Data_6_In  input  1  request line 6
Data_7_In  input  1  request line 7 (highest priority)
Encoded_Value_Out  output  3  index of highest asserted Data_n_In
Valid_Out  output  1  1 when at least one Data_n_In is asserted

Behaviour:
- Priority: Data_7_In > Data_6_In > … > Data_0_In. Encoded_Value_Out = n for the largest n with Data_n_In = 1. Lower-index inputs are don't-care once a higher one is set.
- No input asserted: Encoded_Value_Out = 3'd0 and Valid_Out = 0.
- Any input asserted: Valid_Out = 1.
- REGISTER_OUTPUT=1:
  - The combinational encode result is captured on each rising Clock_In edge.
  - Outputs reflect inputs sampled at the previous edge (latency 1 cycle).
  - Outputs update every cycle; there is no enable and no hold.
- REGISTER_OUTPUT=0: outputs follow inputs combinationally (latency 0).
- Reset:
  - Reset_In = 0 immediately and asynchronously forces Encoded_Value_Out = 3'd0 and Valid_Out = 0, independent of the clock.
  - Outputs are held at those values while reset is low.
  - On release (Reset_In rising to 1), outputs keep their reset values until the first rising clock edge with reset high. At that edge they take the encode of the currently sampled inputs.
  - Reset mid-operation discards the pending result with no residual state.
- X/Z on inputs: no requirement. The bench drives only 0/1 after reset.
- No internal state beyond the output registers. No FSM.
- All 256 input combinations are legal.

Decomposition:
- Shared package: localparam NUM_INPUTS = 8 and ENC_WIDTH = 3. Typedef enc_idx_t as logic [ENC_WIDTH-1:0].
- One natural sub-module: priority_encode_comb. It is purely combinational: 8-bit vector in, index plus valid out. The top module packs Data_7..0 into a vector, instantiates it, and adds the output register stage under REGISTER_OUTPUT.

Test Plan:
- Reset: hold Reset_In=0 with arbitrary inputs (e.g. all 1s) -> Encoded_Value_Out=0 and Valid_Out=0 immediately, with no clock edge needed. Release reset -> outputs stay 0 until the next rising edge, then show 7 / 1.
- All zero: all Data_n_In=0 for one cycle -> next cycle Encoded_Value_Out=0, Valid_Out=0.
- One-hot walk: assert only Data_n_In for n=0..7 on successive cycles -> outputs lag by one cycle, giving 0..7 in order with Valid_Out=1 each cycle. Check that Data_0_In alone gives 0 with Valid_Out=1.
- Priority: inputs 8'b1010_0101 -> 7; 8'b0001_1111 -> 4; 8'b0000_0011 -> 1; 8'b0100_0000 -> 6. Valid_Out=1 in every case.
- Random plus exhaustive: 20 random cycles, then all 256 patterns -> each output matches a reference model (index of highest set bit) one cycle later.
- Async reset mid-run: drop Reset_In between clock edges while inputs = 8'b1000_0000 -> outputs go 0/0 without waiting for a clock edge. Raise reset -> first edge restores 7/1.
